// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;

  // Requester identity; also the index into the 2-way arbiter request vector.
  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // One entry of the 1-deep response pipeline, captured on the grant edge.
  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic       is_write;
    logic [1:0] offset;
  } resp_pipe_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the single-port memory bus.
// slave = arbiter side, master = requesters and memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  import mem_port_arbiter_pkg::*;

  // fetch port
  logic                    i_req_valid;
  logic                    i_req_ready;
  logic [ADDR_WIDTH-1:0]   i_addr;
  logic                    i_resp_valid;
  logic [WORD_W-1:0]       i_rdata;
  // load/store port
  logic                    d_req_valid;
  logic                    d_req_ready;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic                    d_we;
  logic [WORD_W-1:0]       d_wdata;
  logic [STRB_W-1:0]       d_wstrb;
  logic                    d_resp_valid;
  logic [WORD_W-1:0]       d_rdata;
  // memory side
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-3:0]   mem_addr;
  logic [WORD_W-1:0]       mem_wdata;
  logic [STRB_W-1:0]       mem_wstrb;
  logic [WORD_W-1:0]       mem_rdata;

  modport slave (
    input  i_req_valid, i_addr,
    output i_req_ready, i_resp_valid, i_rdata,
    input  d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
    output d_req_ready, d_resp_valid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output i_req_valid, i_addr,
    input  i_req_ready, i_resp_valid, i_rdata,
    output d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
    input  d_req_ready, d_resp_valid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// 2-way round-robin arbiter. req_i[0] is requester I, req_i[1] is D.
// On a tie the requester that did not win last time is granted.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gnt_valid_o,
  output owner_e     gnt_owner_o
);

  owner_e last_grant_q, last_grant_d;

  // Grant decode: single requester wins outright, tie goes away from last winner.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11)
      gnt_o = (last_grant_q == OWNER_D) ? 2'b01 : 2'b10;
    else
      gnt_o = req_i;
  end

  assign gnt_valid_o = |gnt_o;
  assign gnt_owner_o = gnt_o[1] ? OWNER_D : OWNER_I;

  // Last winner only moves when a grant is actually issued.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_valid_o)
      last_grant_d = gnt_owner_o;
  end

  // Reset to D so that I wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= OWNER_D;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous word memory between the fetch
// port (read-only) and the load/store port. One access per cycle, response
// one cycle later, read data shifted down by the byte offset (zero-filled).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              gnt_valid;
  owner_e            gnt_owner;
  logic [1:0]        gnt_offset;
  resp_pipe_t        resp_q, resp_d;
  logic [WORD_W-1:0] rdata_aligned;

  // Requests are masked during reset so nothing reaches the memory that cycle.
  assign req = {bus.d_req_valid, bus.i_req_valid} & {2{~rst}};

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  assign bus.i_req_ready = gnt[0];
  assign bus.d_req_ready = gnt[1];

  // Memory drive for the granted port; strobes only when actually writing.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    gnt_offset    = 2'b00;
    if (gnt_valid) begin
      bus.mem_en = 1'b1;
      if (gnt_owner == OWNER_D) begin
        bus.mem_addr = bus.d_addr[ADDR_WIDTH-1:2];
        gnt_offset   = bus.d_addr[1:0];
        bus.mem_we   = bus.d_we;
        if (bus.d_we) begin
          bus.mem_wdata = bus.d_wdata;
          bus.mem_wstrb = bus.d_wstrb;
        end
      end else begin
        bus.mem_addr = bus.i_addr[ADDR_WIDTH-1:2];
        gnt_offset   = bus.i_addr[1:0];
      end
    end
  end

  // Next pipeline entry describes the access issued this cycle.
  always_comb begin
    resp_d          = '0;
    resp_d.valid    = gnt_valid;
    resp_d.owner    = gnt_owner;
    resp_d.is_write = gnt_valid && (gnt_owner == OWNER_D) && bus.d_we;
    resp_d.offset   = gnt_offset;
  end

  // Response pipeline; reset drops whatever was in flight.
  always_ff @(posedge clk) begin
    if (rst) resp_q <= '0;
    else     resp_q <= resp_d;
  end

  // Byte-offset alignment: low byte of the response is the addressed byte,
  // upper bytes zero-filled, no wrap into the next word.
  assign rdata_aligned = bus.mem_rdata >> {resp_q.offset, 3'b000};

  // Route the response to its owner; write acks carry zero data.
  always_comb begin
    bus.i_resp_valid = resp_q.valid && (resp_q.owner == OWNER_I);
    bus.d_resp_valid = resp_q.valid && (resp_q.owner == OWNER_D);
    bus.i_rdata      = '0;
    bus.d_rdata      = '0;
    if (bus.i_resp_valid)
      bus.i_rdata = rdata_aligned;
    if (bus.d_resp_valid && !resp_q.is_write)
      bus.d_rdata = rdata_aligned;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous word memory between the instruction-fetch requester (port I, read-only) and the load/store requester (port D, read/write). Round-robin arbitration grants at most one access per cycle, and reads and writes are fully pipelined. Response data uses the byte-offset alignment of the existing word memories, so fetch and load units can swap from the combinational dual-port ROM to this arbitrated single-port RAM without changing their alignment logic.

Parameters:
ADDR_WIDTH, 12, byte-address width on both requester ports and the memory side; word address is ADDR_WIDTH-2 bits.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_addr  in  ADDR_WIDTH  fetch byte address
i_resp_valid  out  1  fetch response valid
i_rdata  out  32  fetch read data, byte-offset aligned
d_req_valid  in  1  load/store request valid
d_req_ready  out  1  load/store request accepted this cycle
d_addr  in  ADDR_WIDTH  load/store byte address
d_we  in  1  1 = write, 0 = read
d_wdata  in  32  write data, already lane-positioned
d_wstrb  in  4  byte write enables
d_resp_valid  out  1  load/store response valid (read data or write ack)
d_rdata  out  32  load read data, byte-offset aligned; 0 on write acks
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write
mem_addr  out  ADDR_WIDTH-2  memory word address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte strobes
mem_rdata  in  32  memory read word, valid the cycle after mem_en

Behaviour:
- Reset: all outputs 0; last_grant = D, so I wins the first tie; response pipeline is cleared.
- Grant is combinational in cycle N:
  - only one port valid: that port is granted.
  - both valid: the port other than last_grant is granted.
  - last_grant updates at the clock edge only when a grant occurs.
- req_ready is asserted only for the granted port; the other port's ready is 0. A request is accepted when valid && ready.
- Unaccepted requests must hold their inputs stable until accepted. The arbiter does not latch them.
- Memory drive during a grant cycle:
  - mem_en = 1.
  - mem_addr = granted addr[ADDR_WIDTH-1:2].
  - mem_we = d_we when D is granted, else 0.
  - mem_wdata and mem_wstrb come from the D port; mem_wstrb is forced to 0 when not writing.
- With no grant, mem_en = 0 and the other mem outputs are don't-care (drive 0).
- Pipeline register is captured at the grant edge: {valid, owner, is_write, offset[1:0]}.
- Response in cycle N+1: resp_valid = 1 on the owner port only.
  - read: rdata = mem_rdata >> (8*offset), zero-filled from the top.
  - write: d_rdata = 0.
- Latency is 1 cycle, throughput is 1 access per cycle, and there is no response backpressure. Requesters must always accept responses.
- Back-to-back grants each cycle produce back-to-back responses in grant order. A response and a new grant in the same cycle are independent.
- Starvation bound: with both ports continuously valid, grants strictly alternate I, D, I, D...
- Reset asserted mid-operation: the pending response is dropped (resp_valid = 0 the next cycle) and last_grant returns to D. The memory write issued in the reset cycle is suppressed, because mem_en is gated by !rst.
- Misaligned read (offset != 0): upper bytes are zero-filled, identical to the ROM semantics. No wrap into the next word.
- Write strobes are not checked for alignment; the D port is responsible for them.

Decomposition:
- Shared package: owner encoding (OWNER_I = 0, OWNER_D = 1) and a response-pipeline struct {valid, owner, is_write, offset}.
- One natural sub-module, rr_arbiter2: a 2-way round-robin grant with a last_grant register, reusable for future peripheral buses.
- Alignment shifter stays inline.

Test Plan:
- Reset, then I only: i_addr = 0x010 with memory word 4 = 0xDEADBEEF -> i_req_ready = 1 in cycle 0; cycle 1 i_resp_valid = 1, i_rdata = 0xDEADBEEF, d_resp_valid = 0.
- Both valid continuously for 6 cycles after reset -> grant order I, D, I, D, I, D; each port's ready alternates; the responses trail the grants by exactly 1 cycle.
- D write then read: addr 0x020, wdata 0x11223344, wstrb 0b0011, prior word 0xAABBCCDD -> write ack with d_rdata = 0; read of 0x020 returns 0xAABB3344.
- Misaligned read: d_addr 0x023 on word 0xAABBCCDD -> d_rdata = 0x000000AA; addr 0x021 -> 0x00AABBCC.
- D held while I wins: D valid with I valid and last_grant = D -> D ready = 0 that cycle and D inputs are unchanged; D is granted next cycle with the correct response.
- Reset asserted during a grant cycle with d_we = 1 -> mem_en = 0, memory unchanged, no resp_valid the following cycle, and the next tie after reset goes to I.
